timer_periph: RTL and testbench

TIMER_PERIPH -- requirements
Module: timer_periph

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_if.sv | 11 +
 rtl/timer_prescaler.sv | 17 +
 rtl/timer_periph.sv | 76 +++++++
 tb/tb_timer_periph.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL/STATUS bit positions and reset values for timer_periph.
package timer_pkg;
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } regAddr_e;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PRE_LSB = 8;
    localparam int STAT_EXP     = 0;
    localparam logic [31:0] CTRL_RST  = 32'h0;
    localparam logic [31:0] LOAD_RST  = 32'h0;
    localparam logic [31:0] COUNT_RST = 32'h0;
    localparam logic        EXP_RST   = 1'b0;
endpackage

// File: rtl/timer_if.sv
// timer_if: register bus between the core's address decoder and the timer peripheral.
interface timer_if #(parameter int WIDTH = 32);
    logic             sel;
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;
    modport master(output sel, we, addr, wdata, input rdata, irq);
    modport slave(input sel, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: counts 0..pre while enabled and pulses tick on the terminal value.
module timer_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PRE_W-1:0] pre,
    output logic             tick
);
    logic [PRE_W-1:0] pcnt;
    assign tick = en && pcnt == pre;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pcnt <= '0;
        else pcnt <= (!en || tick) ? '0 : pcnt + 1'b1;
    end
endmodule

// File: rtl/timer_periph.sv
// timer_periph: prescaled down-counter with one-shot/auto-reload expiry and W1C status.
// Define TIMER_IRQ_EN to implement the IE bit and the irq output; otherwise irq is tied low.
module timer_periph
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input logic    clk,
    input logic    rst,
    timer_if.slave bus
);
`ifdef TIMER_IRQ_EN
    localparam logic IE_IMPL = 1'b1;
`else
    localparam logic IE_IMPL = 1'b0;
`endif
    logic             en, autoRl, ie, exp, tick;
    logic [PRE_W-1:0] pre;
    logic [WIDTH-1:0] loadReg, countReg;
    logic             wrEn, ctrlWr, loadWr, statClr, expire;
    logic [PRE_W+7:0] ctrlRd;

    assign wrEn    = bus.sel && bus.we;
    assign ctrlWr  = wrEn && bus.addr == REG_CTRL;
    assign loadWr  = wrEn && bus.addr == REG_LOAD;
    assign statClr = wrEn && bus.addr == REG_STATUS && bus.wdata[STAT_EXP];
    assign expire  = tick && countReg == '0;

    timer_prescaler #(.PRE_W(PRE_W)) uPrescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .pre (pre),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en       <= CTRL_RST[CTRL_EN];
            autoRl   <= CTRL_RST[CTRL_AUTO];
            ie       <= CTRL_RST[CTRL_IE];
            pre      <= CTRL_RST[CTRL_PRE_LSB +: PRE_W];
            loadReg  <= WIDTH'(LOAD_RST);
            countReg <= WIDTH'(COUNT_RST);
            exp      <= EXP_RST;
        end else begin
            // A CTRL write overrides the one-shot auto-clear of EN on the same edge.
            if (ctrlWr) begin
                en     <= bus.wdata[CTRL_EN];
                autoRl <= bus.wdata[CTRL_AUTO];
                ie     <= IE_IMPL & bus.wdata[CTRL_IE];
                pre    <= bus.wdata[CTRL_PRE_LSB +: PRE_W];
            end else if (expire && !autoRl) begin
                en <= 1'b0;
            end
            if (loadWr) loadReg <= bus.wdata;
            countReg <= loadWr ? bus.wdata
                      : !tick ? countReg
                      : countReg != '0 ? countReg - 1'b1
                      : autoRl ? loadReg : '0;
            exp <= expire | (exp & ~statClr);
        end
    end

    assign ctrlRd    = {pre, 5'b0, ie, autoRl, en};
    assign bus.rdata = bus.addr == REG_CTRL  ? WIDTH'(ctrlRd)
                     : bus.addr == REG_LOAD  ? loadReg
                     : bus.addr == REG_COUNT ? countReg
                     : WIDTH'(exp);
`ifdef TIMER_IRQ_EN
    assign bus.irq = exp & ie;
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_timer_periph;
`ifdef TIMER_IRQ_EN
    localparam bit IE_ON = 1'b1;
`else
    localparam bit IE_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bit          mEn, mAuto, mIe, mExp;
    logic [7:0]  mPre, mPcnt;
    logic [31:0] mLoad, mCount;

    timer_if #(.WIDTH(32)) bus ();

    timer_periph #(.WIDTH(32), .PRE_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        mEn = 0; mAuto = 0; mIe = 0; mExp = 0;
        mPre = '0; mPcnt = '0; mLoad = '0; mCount = '0;
    endtask

    // One clock edge of the timer as described by its rules, using the bus inputs now applied.
    task automatic modelEdge();
        bit          tk, nEn, nAuto, nIe, nExp;
        logic [7:0]  nPre, nPcnt;
        logic [31:0] nLoad, nCount;
        tk = mEn && (mPcnt == mPre);
        nPcnt = (!mEn || tk) ? 8'd0 : mPcnt + 8'd1;
        nEn = mEn; nAuto = mAuto; nIe = mIe; nPre = mPre;
        nLoad = mLoad; nCount = mCount; nExp = mExp;
        if (tk) begin
            if (mCount != 0) nCount = mCount - 1;
            else begin
                nExp = 1;
                if (mAuto) nCount = mLoad;
                else begin
                    nEn = 0;
                    nCount = 0;
                end
            end
        end
        if (bus.sel && bus.we) begin
            case (bus.addr)
                2'd0: begin
                    nEn = bus.wdata[0];
                    nAuto = bus.wdata[1];
                    nIe = IE_ON & bus.wdata[2];
                    nPre = bus.wdata[15:8];
                end
                2'd1: begin
                    nLoad = bus.wdata;
                    nCount = bus.wdata;
                end
                2'd3: if (bus.wdata[0] && !(tk && mCount == 0)) nExp = 0;
                default: ;
            endcase
        end
        mEn = nEn; mAuto = nAuto; mIe = nIe; mPre = nPre;
        mPcnt = nPcnt; mLoad = nLoad; mCount = nCount; mExp = nExp;
    endtask

    task automatic tickEdge();
        modelEdge();
        @(posedge clk);
        #1;
        bus.sel = 0;
        bus.we = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.sel = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
        tickEdge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tickEdge();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rdata;
    endtask

    task automatic checkAll(input string tag);
        logic [31:0] v;
        rd(2'd0, v); chk({tag, "_ctrl"}, v, {16'h0, mPre, 5'b0, mIe, mAuto, mEn});
        rd(2'd1, v); chk({tag, "_load"}, v, mLoad);
        rd(2'd2, v); chk({tag, "_count"}, v, mCount);
        rd(2'd3, v); chk({tag, "_status"}, v, {31'h0, mExp});
        chk({tag, "_irq"}, {31'h0, bus.irq}, {31'h0, mExp & mIe});
    endtask

    task automatic doReset();
        rst = 0;
        #1;
        modelReset();
        checkAll("rst");
        @(negedge clk);
        rst = 1;
        tickEdge();
    endtask

    initial begin
        logic [31:0] v, d;
        logic [1:0]  a;
        bus.sel = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0;
        modelReset();
        #2;
        checkAll("por");
        @(negedge clk);
        rst = 1;
        tickEdge();

        // One-shot: expiry exactly four edges after EN
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            idle(1);
            checkAll("oneshot");
            rd(2'd3, v);
            chk("oneshot_exp", v, (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 4) begin
                rd(2'd0, v); chk("oneshot_en_clr", v, 32'h0);
                rd(2'd2, v); chk("oneshot_cnt0", v, 32'h0);
            end
        end

        // Auto-reload with PRE=1: tick every 2 cycles, expiry at cycle 6
        doReset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h0103);
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            checkAll("auto");
            rd(2'd2, v);
            if (i == 2) chk("auto_cnt_c2", v, 32'd1);
            if (i == 4) chk("auto_cnt_c4", v, 32'd0);
            if (i == 6) chk("auto_reload", v, 32'd2);
            rd(2'd3, v);
            chk("auto_exp", v, (i == 6) ? 32'd1 : 32'd0);
        end

        // Interrupt and clear, LOAD=0 expires on every tick
        doReset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h7);
        idle(1);
        checkAll("irq");
        chk("irq_set", {31'h0, bus.irq}, {31'h0, IE_ON});
        rd(2'd0, v); chk("irq_ctrl", v, IE_ON ? 32'h7 : 32'h3);
        wr(2'd3, 32'h1);
        checkAll("irq_clr_coll");
        rd(2'd3, v); chk("clr_vs_expire", v, 32'd1);
        wr(2'd0, 32'h6);
        checkAll("irq_dis");
        wr(2'd3, 32'h1);
        checkAll("irq_clr");
        chk("irq_cleared", {31'h0, bus.irq}, 32'h0);

        // LOAD write colliding with a tick suppresses the decrement
        doReset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h1);
        idle(1);
        wr(2'd1, 32'h10);
        checkAll("coll");
        rd(2'd2, v); chk("coll_count", v, 32'h10);
        wr(2'd2, 32'hdead);
        rd(2'd2, v); chk("count_ro", v, 32'hf);

        // Asynchronous reset mid-count
        doReset();
        wr(2'd1, 32'h55);
        wr(2'd0, 32'hff01);
        idle(3);
        rd(2'd2, v); chk("pre_rst_count", v, 32'h55);
        doReset();
        idle(3);
        checkAll("post_rst");
        rd(2'd2, v); chk("no_resume", v, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) doReset();
            else if ($urandom_range(0, 9) < 6) idle(1);
            else begin
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                if (a == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
                if (a == 2'd1) d = $urandom_range(0, 7);
                wr(a, d);
            end
            checkAll("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
